// File: rtl/key_reset_ctrl.sv
// Push-button and PLL-lock driven system reset controller.
// Synchronizes both async inputs, debounces the key, and sequences sys_reset through a small FSM.
module key_reset_ctrl #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int HOLD_CYCLES     = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_n,
    input  logic       pll_locked,
    output logic       sys_reset,
    output logic       key_press,
    output logic [7:0] reset_count,
    output logic [1:0] state_o
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HD_W = $clog2(HOLD_CYCLES) + 1;
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HD_W-1:0] HOLD_LAST = HD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2,
        KEY_DOWN  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] key_sync_p;
    logic [SYNC_STAGES-1:0] lock_sync_p;
    logic                   key_s;
    logic                   lock_s;
    logic [DB_W-1:0]        db_cnt;
    logic                   key_stable;
    logic [HD_W-1:0]        hold_cnt;
    state_t                 state;
    state_t                 next_state;

    // Synchronizer stages: key idles released (1), lock idles unlocked (0)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_sync_p  <= '1;
            lock_sync_p <= '0;
        end else begin
            key_sync_p  <= {key_sync_p[SYNC_STAGES-2:0], key_n};
            lock_sync_p <= {lock_sync_p[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign key_s  = key_sync_p[SYNC_STAGES-1];
    assign lock_s = lock_sync_p[SYNC_STAGES-1];

    // Debounce stage: the counter only runs while the input disagrees, so it cannot wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_cnt     <= '0;
            key_stable <= 1'b1;
            key_press  <= 1'b0;
        end else begin
            key_press <= 1'b0;
            if (key_s == key_stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt     <= '0;
                key_stable <= key_s;
                key_press  <= key_stable;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            WAIT_LOCK: if (lock_s) next_state = HOLD;
            HOLD:      if (key_stable && hold_cnt == HOLD_LAST) next_state = RUN;
            RUN:       if (key_press) next_state = KEY_DOWN;
            KEY_DOWN:  if (key_stable) next_state = HOLD;
            default:   next_state = WAIT_LOCK;
        endcase
        // Losing lock overrides every other transition
        if (state != WAIT_LOCK && !lock_s)
            next_state = WAIT_LOCK;
    end

    // Sequencer stage: sys_reset is loaded from next_state so it lines up with RUN exactly
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= WAIT_LOCK;
            sys_reset   <= 1'b1;
            hold_cnt    <= '0;
            reset_count <= '0;
        end else begin
            state     <= next_state;
            sys_reset <= (next_state != RUN);
            if (state == HOLD && next_state == HOLD && key_stable)
                hold_cnt <= hold_cnt + 1'b1;
            else
                hold_cnt <= '0;
            if (state == RUN && key_press && reset_count != 8'hFF)
                reset_count <= reset_count + 8'd1;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_key_reset_ctrl.sv
// Directed bench for key_reset_ctrl with short debounce/hold settings.
module tb_key_reset_ctrl;

    localparam int SS = 2;
    localparam int DC = 8;
    localparam int HC = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_n;
    logic       pll_locked;
    logic       sys_reset;
    logic       key_press;
    logic [7:0] reset_count;
    logic [1:0] state_o;

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int press_cnt = 0;
    int press_cyc = 0;

    key_reset_ctrl #(
        .SYNC_STAGES(SS),
        .DEBOUNCE_CYCLES(DC),
        .HOLD_CYCLES(HC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key_n(key_n),
        .pll_locked(pll_locked),
        .sys_reset(sys_reset),
        .key_press(key_press),
        .reset_count(reset_count),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance n cycles, sampling on the falling edge and logging key_press pulses
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            if (key_press) begin
                press_cnt++;
                press_cyc = cyc;
            end
        end
    endtask

    task automatic hold_len(input string tag);
        int n;
        n = 0;
        while (state_o != 2'd1 && n < 300) begin
            step(1);
            n++;
        end
        chk({tag, "_hold_entry"}, (n < 300), 1);
        n = 0;
        while (sys_reset && n < 100) begin
            step(1);
            n++;
        end
        chk({tag, "_hold_len"}, n, HC);
        chk({tag, "_state_run"}, state_o, 2);
    endtask

    task automatic wait_run(input string tag);
        int n;
        n = 0;
        while (!(state_o == 2'd2 && sys_reset == 1'b0) && n < 400) begin
            step(1);
            n++;
        end
        chk({tag, "_run"}, (n < 400), 1);
    endtask

    task automatic press_release(input string tag);
        key_n = 1'b0;
        step(14);
        key_n = 1'b1;
        wait_run(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        int c0;
        int bad;
        int n;

        reset      = 1'b1;
        key_n      = 1'b1;
        pll_locked = 1'b0;
        step(2);
        chk("rst_state", state_o, 0);
        chk("rst_sys_reset", sys_reset, 1);
        chk("rst_count", reset_count, 0);
        chk("rst_key_press", key_press, 0);

        // Power-up
        reset = 1'b0;
        step(3);
        chk("no_lock_wait", state_o, 0);
        pll_locked = 1'b1;
        step(2);
        chk("lock_sync_delay", state_o, 0);
        step(1);
        chk("lock_to_hold", state_o, 1);
        hold_len("powerup");

        // Seven-cycle glitch falls one short of the debounce window
        p0 = press_cnt;
        key_n = 1'b0;
        step(7);
        key_n = 1'b1;
        step(20);
        chk("glitch7_no_press", press_cnt - p0, 0);
        chk("glitch7_state", state_o, 2);

        // Bouncing key
        p0 = press_cnt;
        for (int i = 0; i < 10; i++) begin
            key_n = (i % 2 == 1);
            step(3);
        end
        key_n = 1'b0;
        c0 = cyc;
        step(20);
        chk("bounce_presses", press_cnt - p0, 1);
        chk("bounce_delay", press_cyc - c0, 10);
        chk("bounce_count", reset_count, 1);
        chk("bounce_sys_reset", sys_reset, 1);
        chk("bounce_key_down", state_o, 3);
        key_n = 1'b1;
        hold_len("bounce_rel");
        chk("release_no_press", press_cnt - p0, 1);

        // Exactly eight low cycles is accepted
        p0 = press_cnt;
        key_n = 1'b0;
        c0 = cyc;
        step(8);
        key_n = 1'b1;
        hold_len("exact8");
        chk("exact8_press", press_cnt - p0, 1);
        chk("exact8_delay", press_cyc - c0, 10);
        chk("exact8_count", reset_count, 2);

        // Held key
        p0 = press_cnt;
        key_n = 1'b0;
        step(10);
        chk("held_pulse", key_press, 1);
        chk("held_sys_reset_pre", sys_reset, 0);
        bad = 0;
        for (int i = 0; i < 90; i++) begin
            step(1);
            if (!sys_reset) bad++;
        end
        chk("held_sys_reset_low_cycles", bad, 0);
        chk("held_state", state_o, 3);
        key_n = 1'b1;
        hold_len("held_rel");
        chk("held_presses", press_cnt - p0, 1);
        chk("held_count", reset_count, 3);

        // One-cycle lock loss in RUN
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(2);
        chk("lockloss_state", state_o, 0);
        chk("lockloss_sys_reset", sys_reset, 1);
        hold_len("lockloss");
        chk("lockloss_count", reset_count, 3);

        // Lock loss in the same RUN cycle as key_press
        key_n = 1'b0;
        step(8);
        pll_locked = 1'b0;
        step(2);
        chk("combo_pulse", key_press, 1);
        step(1);
        chk("combo_state", state_o, 0);
        chk("combo_count", reset_count, 4);
        key_n = 1'b1;
        pll_locked = 1'b1;
        wait_run("combo");

        // Saturation
        n = 255 - int'(reset_count);
        for (int i = 0; i < n; i++) press_release("sat");
        chk("sat_reach", reset_count, 255);
        for (int i = 0; i < 9; i++) press_release("sat_over");
        chk("sat_hold", reset_count, 255);

        // Async reset while in KEY_DOWN
        @(negedge clk);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        hold_len("rst2");
        for (int i = 0; i < 4; i++) press_release("pre_async");
        key_n = 1'b0;
        n = 0;
        while (state_o != 2'd3 && n < 40) begin
            step(1);
            n++;
        end
        chk("async_in_key_down", state_o, 3);
        chk("async_pre_count", reset_count, 5);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_state", state_o, 0);
        chk("async_sys_reset", sys_reset, 1);
        chk("async_count", reset_count, 0);
        chk("async_key_press", key_press, 0);
        @(negedge clk);
        key_n = 1'b1;
        reset = 1'b0;
        hold_len("restart");
        chk("restart_count", reset_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_reset_ctrl.md
KEY_RESET_CTRL -- requirements
Module: key_reset_ctrl

Interface
REQ-001 The block SHALL provide parameter SYNC_STAGES, default 2, number of synchronizer flops on each asynchronous input (minimum 2).
REQ-002 The block SHALL provide parameter DEBOUNCE_CYCLES, default 10000, consecutive stable cycles required to accept a key level change (1 ms at 10 MHz).
REQ-003 The block SHALL provide parameter HOLD_CYCLES, default 32, cycles sys_reset stays asserted after all reset causes clear.
REQ-004 The block SHALL provide port clk  input  1  system clock (PLL c0 domain).
REQ-005 The block SHALL provide port reset  input  1  one clock; reset is asynchronous and active-high.
REQ-006 The block SHALL provide port key_n  input  1  raw push-button, active-low, asynchronous, bouncing.
REQ-007 The block SHALL provide port pll_locked  input  1  PLL lock indicator, asynchronous.
REQ-008 The block SHALL provide port sys_reset  output  1  registered active-high reset to the SoC.
REQ-009 The block SHALL provide port key_press  output  1  one-cycle pulse on each debounced press.
REQ-010 The block SHALL provide port reset_count  output  8  number of key-initiated resets, saturating.
REQ-011 The block SHALL provide port state_o  output  2  current FSM state for debug/LED.

Function
REQ-012 key_n and pll_locked SHALL each pass through SYNC_STAGES flops before any use; key synchronizer resets to 1, lock synchronizer to 0.
REQ-013 Debouncer: key_stable SHALL change to the synchronized key level only after DEBOUNCE_CYCLES consecutive cycles differing from key_stable; any cycle matching key_stable clears the counter to 0.
REQ-014 Debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES)+1; it SHALL never wrap.
REQ-015 key_press SHALL be high for exactly the one cycle after key_stable transitions 1->0; release produces no pulse.
REQ-016 FSM states SHALL be WAIT_LOCK=0, HOLD=1, RUN=2, KEY_DOWN=3, visible on state_o.
REQ-017 WAIT_LOCK: hold counter cleared; go to HOLD when synchronized lock=1.
REQ-018 HOLD: hold counter increments each cycle; go to RUN when counter reaches HOLD_CYCLES-1; counter SHALL be held at 0 while key_stable=0.
REQ-019 RUN: go to KEY_DOWN on key_press; reset_count increments by 1, saturating at 255.
REQ-020 KEY_DOWN: go to HOLD with counter 0 when key_stable=1.
REQ-021 From HOLD, RUN or KEY_DOWN, synchronized lock=0 SHALL force WAIT_LOCK next cycle, with priority over all other transitions.
REQ-022 sys_reset SHALL be a flop loaded with (next_state != RUN), so it deasserts in the first RUN cycle and reasserts in the first cycle after leaving RUN; no combinational path to the output.
REQ-023 Entering HOLD at cycle N with no key or lock event SHALL yield sys_reset=0 at cycle N+HOLD_CYCLES.
REQ-024 Lock loss and key_press in the same RUN cycle SHALL go to WAIT_LOCK and SHALL still increment reset_count.

Reset
REQ-025 On reset assertion, asynchronously: state=WAIT_LOCK, sys_reset=1, key_press=0, reset_count=0, key_stable=1, all counters 0, synchronizers to values in REQ-012.
REQ-026 Reset asserted mid-operation (any state) SHALL take effect immediately, without waiting for a clock edge; after release the sequence restarts from WAIT_LOCK.
REQ-027 reset_count SHALL clear only on reset, never on key-initiated resets.

Verification (DEBOUNCE_CYCLES=8, HOLD_CYCLES=16, SYNC_STAGES=2)
REQ-028 Power-up: reset pulse, pll_locked=1 at cycle 0 -> state WAIT_LOCK, HOLD at cycle 2-3, sys_reset falls exactly 16 cycles after HOLD entry, state_o=2.
REQ-029 Bounce: in RUN, key_n toggles every 3 cycles for 30 cycles then stays 0 -> exactly one key_press, 8 cycles after last toggle plus sync delay; reset_count=1; sys_reset=1.
REQ-030 Held key: keep key_n=0 for 100 cycles then release -> sys_reset stays 1 throughout; falls 16 cycles after HOLD entry following debounced release.
REQ-031 Lock loss: in RUN drop pll_locked for 1 cycle -> WAIT_LOCK, sys_reset=1, full 16-cycle HOLD after relock.
REQ-032 Saturation: 260 debounced presses -> reset_count=255, no wrap to 0.
REQ-033 Async reset in KEY_DOWN with reset_count=5 -> same-cycle sys_reset=1, reset_count=0, state_o=0 before next clk edge.
